decode_queue: RTL and testbench

- Decode stage with a parametrised-depth instruction queue between fetch and execute.
- Absorbs up to DEPTH fetched instructions, together with their PC and fetch exceptions, so fetch keeps running while execute stalls.
- Decodes the queue head through the existing decode_inst combinational decoder.
- Successor to the single-entry decode buffer: adds configurable depth, an occupancy output, and exception_valid_out qualified by occupancy.

---
 rtl/decode_queue.sv | 152 +++++++++++++++
 tb/tb_decode_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Decode stage: a DEPTH-entry circular instruction queue between fetch and execute,
// whose head is decoded combinationally by decode_inst.

module decode_inst (
    input  logic [31:0] inst,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic        decode_valid
);
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    always_comb begin
        imm          = '0;
        decode_valid = 1'b1;
        case (inst[6:0])
            7'h03, 7'h13, 7'h67, 7'h73, 7'h0F:
                imm = {{20{inst[31]}}, inst[31:20]};
            7'h23:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            7'h63:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            7'h37, 7'h17:
                imm = {inst[31:12], 12'h000};
            7'h6F:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            7'h33:
                imm = '0;
            default:
                decode_valid = 1'b0;
        endcase
    end
endmodule

module decode_queue #(
    parameter int DEPTH     = 4,
    parameter int PC_WIDTH  = 32,
    parameter int EXC_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                inst,
    input  logic [PC_WIDTH-1:0]        inst_pc,
    input  logic                       inst_valid,
    input  logic [EXC_WIDTH-1:0]       exception_num_in,
    input  logic                       exception_valid_in,
    output logic                       fetch_stall,
    input  logic                       flush,
    output logic [6:0]                 opcode,
    output logic [4:0]                 rd,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    output logic [2:0]                 funct3,
    output logic [6:0]                 funct7,
    output logic [31:0]                imm,
    output logic [PC_WIDTH-1:0]        inst_pc_out,
    output logic                       valid,
    input  logic                       stall,
    output logic [EXC_WIDTH-1:0]       exception_num_out,
    output logic                       exception_valid_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]          mem_inst      [DEPTH];
    logic [PC_WIDTH-1:0]  mem_pc        [DEPTH];
    logic [EXC_WIDTH-1:0] mem_exc_num   [DEPTH];
    logic                 mem_exc_valid [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic decode_valid;
    logic head_exc_valid;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = ~empty & ~stall & ~flush;
    // A full queue still takes a new entry when the head leaves in the same cycle.
    assign push  = inst_valid & ~flush & (~full | pop);

    assign valid       = pop;
    assign fetch_stall = ~flush & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst[i]      <= '0;
                mem_pc[i]        <= '0;
                mem_exc_num[i]   <= '0;
                mem_exc_valid[i] <= 1'b0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_inst[wr_ptr]      <= inst;
                mem_pc[wr_ptr]        <= inst_pc;
                mem_exc_num[wr_ptr]   <= exception_num_in;
                mem_exc_valid[wr_ptr] <= exception_valid_in;
                wr_ptr                <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    decode_inst u_decode (
        .inst         (mem_inst[rd_ptr]),
        .opcode       (opcode),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .funct3       (funct3),
        .funct7       (funct7),
        .imm          (imm),
        .decode_valid (decode_valid)
    );

    assign inst_pc_out    = mem_pc[rd_ptr];
    assign head_exc_valid = mem_exc_valid[rd_ptr];

    // Fetch exceptions outrank the illegal-instruction code (2).
    assign exception_valid_out = ~empty & (head_exc_valid | ~decode_valid);
    assign exception_num_out   = head_exc_valid ? mem_exc_num[rd_ptr]
                               : (~decode_valid ? EXC_WIDTH'(2) : EXC_WIDTH'(0));
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: a per-cycle vector table plus hand-written
// sequences for fill/drain, wrap, flush and reset.

module tb_decode_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic [5:0]  exception_num_in;
    logic        exception_valid_in;
    logic        fetch_stall;
    logic        flush;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] inst_pc_out;
    logic        valid;
    logic        stall;
    logic [5:0]  exception_num_out;
    logic        exception_valid_out;
    logic [2:0]  count;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    decode_queue dut (
        .clk                 (clk),
        .reset               (reset),
        .inst                (inst),
        .inst_pc             (inst_pc),
        .inst_valid          (inst_valid),
        .exception_num_in    (exception_num_in),
        .exception_valid_in  (exception_valid_in),
        .fetch_stall         (fetch_stall),
        .flush               (flush),
        .opcode              (opcode),
        .rd                  (rd),
        .rs1                 (rs1),
        .rs2                 (rs2),
        .funct3              (funct3),
        .funct7              (funct7),
        .imm                 (imm),
        .inst_pc_out         (inst_pc_out),
        .valid               (valid),
        .stall               (stall),
        .exception_num_out   (exception_num_out),
        .exception_valid_out (exception_valid_out),
        .count               (count)
    );

    typedef struct {
        logic        rst, iv;
        logic [31:0] ins, pc;
        logic        ev;
        logic [5:0]  en;
        logic        fl, st;
        logic        e_valid, e_fs;
        logic [2:0]  e_cnt;
        logic        e_exv;
        logic        chk_head;
        logic [5:0]  e_exn;
        logic [31:0] e_pc;
        logic        chk_dec;
        logic [6:0]  e_op;
        logic [4:0]  e_rd, e_rs1, e_rs2;
        logic [2:0]  e_f3;
        logic [31:0] e_imm;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic r, iv, input logic [31:0] ins, pc,
                                input logic ev, input logic [5:0] en, input logic fl, st,
                                input logic e_valid, e_fs, input logic [2:0] e_cnt,
                                input logic e_exv, chk_head, input logic [5:0] e_exn,
                                input logic [31:0] e_pc);
        vec_t t;
        t.rst = r; t.iv = iv; t.ins = ins; t.pc = pc; t.ev = ev; t.en = en;
        t.fl = fl; t.st = st; t.e_valid = e_valid; t.e_fs = e_fs; t.e_cnt = e_cnt;
        t.e_exv = e_exv; t.chk_head = chk_head; t.e_exn = e_exn; t.e_pc = e_pc;
        t.chk_dec = 1'b0; t.e_op = '0; t.e_rd = '0; t.e_rs1 = '0; t.e_rs2 = '0;
        t.e_f3 = '0; t.e_imm = '0;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic r, iv, input logic [31:0] ins, pc,
                       input logic ev, input logic [5:0] en, input logic fl, st);
        @(negedge clk);
        reset = r; inst_valid = iv; inst = ins; inst_pc = pc;
        exception_valid_in = ev; exception_num_in = en; flush = fl; stall = st;
        #1;
    endtask

    task automatic push_nop(input logic [31:0] pc, input logic st);
        drv(1'b0, 1'b1, 32'h00000013, pc, 1'b0, 6'd0, 1'b0, st);
    endtask

    task automatic idle(input logic st);
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 1'b0, st);
    endtask

    task automatic chk_state(input string tag, input logic e_valid, e_fs,
                             input logic [2:0] e_cnt);
        check({tag, " valid"}, 32'(valid), 32'(e_valid));
        check({tag, " fetch_stall"}, 32'(fetch_stall), 32'(e_fs));
        check({tag, " count"}, 32'(count), 32'(e_cnt));
    endtask

    logic [31:0] head_exp;

    initial begin
        tbl[0]  = mk(0,0,32'h0,32'h0,0,0,0,0,                     0,0,0,0, 0,0,32'h0);
        tbl[1]  = mk(0,1,32'h00500093,32'h100,0,0,0,0,            0,0,0,0, 0,0,32'h0);
        tbl[2]  = mk(0,0,32'h0,32'h0,0,0,0,0,                     1,0,1,0, 1,0,32'h100);
        tbl[2].chk_dec = 1; tbl[2].e_op = 7'h13; tbl[2].e_rd = 1; tbl[2].e_rs1 = 0;
        tbl[2].e_rs2 = 5; tbl[2].e_f3 = 0; tbl[2].e_imm = 32'd5;
        tbl[3]  = mk(0,1,32'h0,32'h200,1,6'd1,0,1,                0,0,0,0, 0,0,32'h0);
        tbl[4]  = mk(0,1,32'hFFFFFFFF,32'h204,0,0,0,1,            0,0,1,1, 1,6'd1,32'h200);
        tbl[5]  = mk(0,0,32'h0,32'h0,0,0,0,0,                     1,0,2,1, 1,6'd1,32'h200);
        tbl[6]  = mk(0,0,32'h0,32'h0,0,0,0,0,                     1,0,1,1, 1,6'd2,32'h204);
        tbl[7]  = mk(0,0,32'h0,32'h0,0,0,0,0,                     0,0,0,0, 0,0,32'h0);
        tbl[8]  = mk(0,1,32'h0020A423,32'h300,0,0,0,0,            0,0,0,0, 0,0,32'h0);
        tbl[9]  = mk(0,0,32'h0,32'h0,0,0,0,0,                     1,0,1,0, 1,0,32'h300);
        tbl[9].chk_dec = 1; tbl[9].e_op = 7'h23; tbl[9].e_rd = 5'd8; tbl[9].e_rs1 = 1;
        tbl[9].e_rs2 = 2; tbl[9].e_f3 = 3'd2; tbl[9].e_imm = 32'd8;
        tbl[10] = mk(0,0,32'h0,32'h0,0,0,0,0,                     0,0,0,0, 0,0,32'h0);

        reset = 1'b1; inst_valid = 1'b0; inst = '0; inst_pc = '0;
        exception_valid_in = 1'b0; exception_num_in = '0; flush = 1'b0; stall = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            drv(tbl[i].rst, tbl[i].iv, tbl[i].ins, tbl[i].pc, tbl[i].ev, tbl[i].en,
                tbl[i].fl, tbl[i].st);
            chk_state($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_fs, tbl[i].e_cnt);
            check($sformatf("row%0d exc_valid", i), 32'(exception_valid_out), 32'(tbl[i].e_exv));
            if (tbl[i].chk_head) begin
                check($sformatf("row%0d exc_num", i), 32'(exception_num_out), 32'(tbl[i].e_exn));
                check($sformatf("row%0d pc", i), inst_pc_out, tbl[i].e_pc);
            end
            if (tbl[i].chk_dec) begin
                check($sformatf("row%0d opcode", i), 32'(opcode), 32'(tbl[i].e_op));
                check($sformatf("row%0d rd", i), 32'(rd), 32'(tbl[i].e_rd));
                check($sformatf("row%0d rs1", i), 32'(rs1), 32'(tbl[i].e_rs1));
                check($sformatf("row%0d rs2", i), 32'(rs2), 32'(tbl[i].e_rs2));
                check($sformatf("row%0d funct3", i), 32'(funct3), 32'(tbl[i].e_f3));
                check($sformatf("row%0d imm", i), imm, tbl[i].e_imm);
            end
        end

        // Fill under stall, fifth instruction held, then drain in order.
        for (int k = 0; k < 5; k++) begin
            push_nop(32'(4*k), 1'b1);
            chk_state($sformatf("fill%0d", k), 1'b0, (k == 4), 3'(k < 4 ? k : 4));
        end
        push_nop(32'h10, 1'b0);
        chk_state("fill release", 1'b1, 1'b0, 3'd4);
        check("fill release pc", inst_pc_out, 32'h0);
        for (int k = 1; k < 5; k++) begin
            idle(1'b0);
            chk_state($sformatf("drain%0d", k), 1'b1, 1'b0, 3'(5 - k));
            check($sformatf("drain%0d pc", k), inst_pc_out, 32'(4*k));
        end
        idle(1'b0);
        chk_state("drain end", 1'b0, 1'b0, 3'd0);

        // Full queue streaming through pointer wrap.
        for (int k = 0; k < 4; k++) push_nop(32'h1000 + 32'(4*k), 1'b1);
        head_exp = 32'h1000;
        for (int c = 0; c < 20; c++) begin
            push_nop(32'h1010 + 32'(4*c), 1'b0);
            chk_state($sformatf("stream%0d", c), 1'b1, 1'b0, 3'd4);
            check($sformatf("stream%0d pc", c), inst_pc_out, head_exp);
            head_exp += 32'd4;
        end
        for (int c = 0; c < 4; c++) begin
            idle(1'b0);
            check($sformatf("sdrain%0d pc", c), inst_pc_out, head_exp);
            check($sformatf("sdrain%0d valid", c), 32'(valid), 32'd1);
            head_exp += 32'd4;
        end
        idle(1'b0);
        chk_state("stream end", 1'b0, 1'b0, 3'd0);

        // Flush with three queued entries and an incoming instruction.
        for (int k = 0; k < 3; k++) push_nop(32'h300 + 32'(4*k), 1'b1);
        drv(1'b0, 1'b1, 32'h00000013, 32'h30C, 1'b0, 6'd0, 1'b1, 1'b0);
        chk_state("flush cycle", 1'b0, 1'b0, 3'd3);
        idle(1'b0);
        chk_state("after flush", 1'b0, 1'b0, 3'd0);
        check("after flush exc_valid", 32'(exception_valid_out), 32'd0);
        idle(1'b0);
        chk_state("flush dropped", 1'b0, 1'b0, 3'd0);

        // Flush while full must drop fetch_stall immediately.
        for (int k = 0; k < 4; k++) push_nop(32'h600 + 32'(4*k), 1'b1);
        push_nop(32'h610, 1'b1);
        chk_state("full held", 1'b0, 1'b1, 3'd4);
        drv(1'b0, 1'b1, 32'h00000013, 32'h610, 1'b0, 6'd0, 1'b1, 1'b1);
        chk_state("full flush", 1'b0, 1'b0, 3'd4);
        idle(1'b0);
        chk_state("full flush after", 1'b0, 1'b0, 3'd0);

        // Reset mid-operation, then first push after reset.
        for (int k = 0; k < 3; k++) push_nop(32'h400 + 32'(4*k), 1'b1);
        drv(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1);
        check("pre-reset count", 32'(count), 32'd3);
        idle(1'b1);
        chk_state("post reset", 1'b0, 1'b0, 3'd0);
        check("post reset exc_valid", 32'(exception_valid_out), 32'd0);
        push_nop(32'h500, 1'b0);
        chk_state("reset push", 1'b0, 1'b0, 3'd0);
        idle(1'b0);
        chk_state("reset head", 1'b1, 1'b0, 3'd1);
        check("reset head pc", inst_pc_out, 32'h500);
        idle(1'b0);
        chk_state("reset end", 1'b0, 1'b0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
